// File: rtl/i2c_write_sequencer.sv
// Single-byte I2C write controller. Both edges of the baud generator's output
// are half-bit ticks; SCL/SDA are decoded from the sequencing state.
module i2c_write_sequencer #(
    parameter int ADDR_BITS   = 7,
    parameter bit IGNORE_NACK = 1'b0
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 go_i,
    input  logic [ADDR_BITS-1:0] slave_addr_i,
    input  logic [7:0]           write_data_i,
    input  logic                 clock_i2c_i,
    output logic                 baud_enable_o,
    output logic                 scl_o,
    output logic                 sda_out_o,
    output logic                 sda_out_enable_o,
    input  logic                 sda_in_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ack_error_o
);
    localparam int MAX_BITS = (ADDR_BITS > 7) ? ADDR_BITS : 7;
    localparam int CW       = $clog2(MAX_BITS + 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_LO, ADDR_HI, ACK1_LO, ACK1_HI,
        DATA_LO, DATA_HI, ACK2_LO, ACK2_HI, STOP_LO, STOP_HI
    } state_t;

    state_t             state_q, state_d;
    logic               clk_prev_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ADDR_BITS:0] addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               ack_error_q, ack_error_d;
    logic               done_q, done_d;
    logic               tick;

    // Either generator edge is a tick; anything seen while idle is dropped.
    assign tick = (clock_i2c_i != clk_prev_q) && (state_q != IDLE);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            clk_prev_q  <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            ack_error_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_prev_q  <= clock_i2c_i;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ack_error_q <= ack_error_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        ack_error_d = ack_error_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A Go coinciding with the Done pulse is not a new request.
                if (go_i && !done_q) begin
                    addr_d      = {slave_addr_i, 1'b0};
                    data_d      = write_data_i;
                    ack_error_d = 1'b0;
                    state_d     = START;
                end
            end
            START: if (tick) begin
                cnt_d   = CW'(ADDR_BITS);
                state_d = ADDR_LO;
            end
            ADDR_LO: if (tick) state_d = ADDR_HI;
            ADDR_HI: if (tick) begin
                if (cnt_q == '0) begin
                    state_d = ACK1_LO;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = ADDR_LO;
                end
            end
            ACK1_LO: if (tick) state_d = ACK1_HI;
            ACK1_HI: if (tick) begin
                if (sda_in_i) ack_error_d = 1'b1;
                if (!sda_in_i || IGNORE_NACK) begin
                    cnt_d   = CW'(7);
                    state_d = DATA_LO;
                end else begin
                    state_d = STOP_LO;
                end
            end
            DATA_LO: if (tick) state_d = DATA_HI;
            DATA_HI: if (tick) begin
                if (cnt_q == '0) begin
                    state_d = ACK2_LO;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = DATA_LO;
                end
            end
            ACK2_LO: if (tick) state_d = ACK2_HI;
            ACK2_HI: if (tick) begin
                if (sda_in_i) ack_error_d = 1'b1;
                state_d = STOP_LO;
            end
            STOP_LO: if (tick) state_d = STOP_HI;
            STOP_HI: if (tick) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_o            = 1'b1;
        sda_out_enable_o = 1'b0;
        busy_o           = 1'b1;
        baud_enable_o    = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o        = 1'b0;
                baud_enable_o = 1'b0;
            end
            START:   sda_out_enable_o = 1'b1;
            ADDR_LO: begin
                scl_o            = 1'b0;
                sda_out_enable_o = ~addr_q[cnt_q];
            end
            ADDR_HI: sda_out_enable_o = ~addr_q[cnt_q];
            ACK1_LO, ACK2_LO: scl_o = 1'b0;
            DATA_LO: begin
                scl_o            = 1'b0;
                sda_out_enable_o = ~data_q[cnt_q[2:0]];
            end
            DATA_HI: sda_out_enable_o = ~data_q[cnt_q[2:0]];
            STOP_LO: begin
                scl_o            = 1'b0;
                sda_out_enable_o = 1'b1;
            end
            STOP_HI: sda_out_enable_o = 1'b1;
            default: ;
        endcase
    end

    assign sda_out_o   = 1'b0;
    assign done_o      = done_q;
    assign ack_error_o = ack_error_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: two instances (IGNORE_NACK 0 and 1) share stimulus,
// each with its own baud generator and a tick-indexed waveform model.
module tb_i2c_write_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic [6:0] slave_addr = '0;
    logic [7:0] write_data = '0;
    bit         nack1 = 1'b0;
    bit         nack2 = 1'b0;

    logic ci2c   [2] = '{1'b0, 1'b0};
    logic sda_in [2] = '{1'b1, 1'b1};
    logic baud [2], scl [2], sdao [2], oe [2], busy [2], done [2], aerr [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        i2c_write_sequencer #(.ADDR_BITS(7), .IGNORE_NACK(gi == 1)) u_dut (
            .clock_i          (clk),
            .reset_n_i        (rst_n),
            .go_i             (go),
            .slave_addr_i     (slave_addr),
            .write_data_i     (write_data),
            .clock_i2c_i      (ci2c[gi]),
            .baud_enable_o    (baud[gi]),
            .scl_o            (scl[gi]),
            .sda_out_o        (sdao[gi]),
            .sda_out_enable_o (oe[gi]),
            .sda_in_i         (sda_in[gi]),
            .busy_o           (busy[gi]),
            .done_o           (done[gi]),
            .ack_error_o      (aerr[gi])
        );
    end

    // Behavioural model: k counts ticks since Go acceptance (k=0 is START).
    int         m_k     [2] = '{0, 0};
    bit         m_busy  [2] = '{0, 0};
    bit         m_done  [2] = '{0, 0};
    bit         m_err   [2] = '{0, 0};
    bit         m_prev  [2] = '{0, 0};
    bit         m_abort [2] = '{0, 0};
    logic [7:0] m_addr  [2] = '{8'h0, 8'h0};
    logic [7:0] m_data  [2] = '{8'h0, 8'h0};
    bit         m_tick, m_was_done;

    // Expected {SCL, SDA-pull} during half-period k of a transaction.
    function automatic logic [1:0] exp_wave(int k, bit abort, logic [7:0] a, logic [7:0] d);
        if (k == 0)  return 2'b11;
        if (k <= 16) return {((k - 1) % 2) == 1, ~a[7 - (k - 1) / 2]};
        if (k <= 18) return {k == 18, 1'b0};
        if (abort)   return {k == 20, 1'b1};
        if (k <= 34) return {((k - 19) % 2) == 1, ~d[7 - (k - 19) / 2]};
        if (k <= 36) return {k == 36, 1'b0};
        return {k == 38, 1'b1};
    endfunction

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                m_k[j] = 0; m_busy[j] = 0; m_done[j] = 0; m_err[j] = 0;
                m_prev[j] = 0; m_abort[j] = 0;
            end else begin
                m_tick     = (ci2c[j] != m_prev[j]) && m_busy[j];
                m_prev[j]  = ci2c[j];
                m_was_done = m_done[j];
                m_done[j]  = 1'b0;
                if (!m_busy[j]) begin
                    if (go && !m_was_done) begin
                        m_busy[j] = 1; m_k[j] = 0; m_err[j] = 0; m_abort[j] = 0;
                        m_addr[j] = {slave_addr, 1'b0};
                        m_data[j] = write_data;
                    end
                end else if (m_tick) begin
                    m_k[j]++;
                    if (m_k[j] == 19 && sda_in[j] == 1'b1) begin
                        m_err[j] = 1;
                        if (j == 0) m_abort[j] = 1;
                    end
                    if (m_k[j] == 37 && !m_abort[j] && sda_in[j] == 1'b1) m_err[j] = 1;
                    if (m_k[j] == (m_abort[j] ? 21 : 39)) begin
                        m_busy[j] = 0;
                        m_done[j] = 1;
                    end
                end
            end
        end
    end

    // Baud generator (toggles every 5 enabled clocks) and slave ACK driver.
    int gen_cnt [2] = '{0, 0};
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!baud[j]) begin
                gen_cnt[j] = 0;
            end else begin
                gen_cnt[j]++;
                if (gen_cnt[j] == 5) begin
                    gen_cnt[j] = 0;
                    ci2c[j] = ~ci2c[j];
                end
            end
            if (m_busy[j] && (m_k[j] == 17 || m_k[j] == 18))
                sda_in[j] = nack1;
            else if (m_busy[j] && !m_abort[j] && (m_k[j] == 35 || m_k[j] == 36))
                sda_in[j] = nack2;
            else
                sda_in[j] = 1'b1;
        end
    end

    // Per-cycle compare plus capture of line bits at each SCL rise.
    int          lat      [2] = '{0, 0};
    int          capn     [2] = '{0, 0};
    logic [31:0] cap      [2] = '{32'h0, 32'h0};
    int          rec_lat  [2] = '{0, 0};
    int          rec_n    [2] = '{0, 0};
    logic [31:0] rec_bits [2] = '{32'h0, 32'h0};
    logic        scl_s    [2] = '{1'b1, 1'b1};
    logic [6:0]  exp_v, act_v;
    logic [1:0]  w;

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                exp_v = 7'b1000000;
            end else if (!m_busy[j]) begin
                exp_v = {5'b10000, m_done[j], m_err[j]};
            end else begin
                w = exp_wave(m_k[j], m_abort[j], m_addr[j], m_data[j]);
                exp_v = {w[1], w[0], 3'b011, 1'b0, m_err[j]};
            end
            act_v = {scl[j], oe[j], sdao[j], busy[j], baud[j], done[j], aerr[j]};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle inst%0d t=%0t k=%0d scl,oe,sdao,busy,baud,done,aerr got %b want %b",
                         j, $time, m_k[j], act_v, exp_v);
            end
            if (!rst_n) begin
                lat[j] = 0; cap[j] = '0; capn[j] = 0;
            end else begin
                if (busy[j]) lat[j]++;
                if (scl[j] && !scl_s[j]) begin
                    cap[j] = {cap[j][30:0], oe[j] ? 1'b0 : sda_in[j]};
                    capn[j]++;
                end
                if (done[j]) begin
                    rec_lat[j] = lat[j]; rec_bits[j] = cap[j]; rec_n[j] = capn[j];
                    lat[j] = 0; cap[j] = '0; capn[j] = 0;
                end
            end
            scl_s[j] = scl[j];
        end
    end

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h want %0h", name, j, act, exp);
        end
    endtask

    task automatic start_txn(input logic [6:0] a, input logic [7:0] d, input bit n1, input bit n2);
        @(negedge clk);
        slave_addr = a; write_data = d; nack1 = n1; nack2 = n2; go = 1'b1;
        rec_lat[0] = -1; rec_lat[1] = -1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((m_busy[0] || m_busy[1]) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (m_busy[0] || m_busy[1]) begin
            errors++;
            $display("FAIL timeout waiting for transaction end: busy %0d/%0d want 0/0", m_busy[0], m_busy[1]);
        end
    endtask

    task automatic check_result(input int j, input int exp_lat, input logic [31:0] exp_bits,
                                input int exp_n, input bit exp_err);
        chk("done_latency_clocks", j, 32'(rec_lat[j]), 32'(exp_lat));
        chk("sda_bits_at_scl_rise", j, rec_bits[j], exp_bits);
        chk("scl_rise_count", j, 32'(rec_n[j]), 32'(exp_n));
        chk("ack_error_held", j, 32'(aerr[j]), 32'(exp_err));
        $display("txn inst%0d addr=%h data=%h latency=%0d bits=%0h nbits=%0d ack_error=%0d",
                 j, slave_addr, write_data, rec_lat[j], rec_bits[j], rec_n[j], aerr[j]);
    endtask

    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input bit n1, input bit n2,
                           input int lat0, input logic [31:0] bits0, input int nb0, input bit e0,
                           input int lat1, input logic [31:0] bits1, input int nb1, input bit e1);
        start_txn(a, d, n1, n2);
        wait_idle();
        @(negedge clk);
        check_result(0, lat0, bits0, nb0, e0);
        check_result(1, lat1, bits1, nb1, e1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++)
            chk("reset_outputs", j, 32'({scl[j], oe[j], sdao[j], busy[j], baud[j], done[j], aerr[j]}),
                32'(7'b1000000));
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full ACKed write.
        run_txn(7'h48, 8'hA5, 0, 0,
                195, 32'(19'b1001_0000_0_1010_0101_0_0), 19, 0,
                195, 32'(19'b1001_0000_0_1010_0101_0_0), 19, 0);
        // Address NACK: instance 0 aborts to STOP, instance 1 still sends the data byte.
        run_txn(7'h48, 8'hA5, 1, 0,
                105, 32'(10'b1001_0000_1_0), 10, 1,
                195, 32'(19'b1001_0000_1_1010_0101_0_0), 19, 1);
        // Data NACK only.
        run_txn(7'h2C, 8'h3C, 0, 1,
                195, 32'(19'b0101_1000_0_0011_1100_1_0), 19, 1,
                195, 32'(19'b0101_1000_0_0011_1100_1_0), 19, 1);
        // Next accepted Go clears AckError.
        run_txn(7'h7F, 8'h00, 0, 0,
                195, 32'(19'b1111_1110_0_0000_0000_0_0), 19, 0,
                195, 32'(19'b1111_1110_0_0000_0000_0_0), 19, 0);

        // Go pulsed mid-transaction and in the Done cycle.
        start_txn(7'h55, 8'h81, 0, 0);
        repeat (40) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 0;
        while (!m_done[0] && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen_before_timeout", 0, 32'(m_done[0]), 32'd1);
        go = 1'b1;
        @(negedge clk);
        chk("go_in_done_cycle_ignored", 0, 32'(busy[0]), 32'd0);
        @(negedge clk);
        go = 1'b0;
        chk("go_next_cycle_accepted", 0, 32'(busy[0]), 32'd1);
        chk("start_scl_sda_pull", 0, 32'({scl[0], oe[0]}), 32'(2'b11));
        wait_idle();
        @(negedge clk);
        check_result(0, 195, 32'(19'b1010_1010_0_1000_0001_0_0), 19, 0);

        // Asynchronous reset mid-DATA phase.
        start_txn(7'h48, 8'hA5, 0, 0);
        cyc = 0;
        while (m_k[0] < 24 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_data_phase", 0, 32'(m_k[0] >= 24), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        for (int j = 0; j < 2; j++)
            chk("async_reset_scl_oe_baud_busy", j, 32'({scl[j], oe[j], baud[j], busy[j]}), 32'(4'b1000));
        @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_txn(7'h48, 8'hA5, 0, 0,
                195, 32'(19'b1001_0000_0_1010_0101_0_0), 19, 0,
                195, 32'(19'b1001_0000_0_1010_0101_0_0), 19, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_write_sequencer.md
Name: i2c_write_sequencer

Overview:
- Transaction controller for the I2C baud-rate generator.
- On a Go request it enables the generator and uses each edge of the generator's ClockI2C as a half-bit tick.
- Over those ticks it sequences one complete I2C single-byte write: START, 7-bit address + W, ACK, data byte, ACK, STOP.
- It drives SCL and an open-drain SDA, and reports Busy, Done and AckError to the host logic.

Parameters:
- ADDR_BITS, 7: slave address width. The address phase is ADDR_BITS+1 bits; the last bit is R/W, fixed 0.
- IGNORE_NACK, 0: 1 = continue to the data phase after an address NACK, with AckError still set. 0 = go straight to STOP.

Ports:
- clock, input, 1: system clock; all logic is on its rising edge.
- Reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- Go, input, 1: start request; sampled only in IDLE.
- SlaveAddr, input, ADDR_BITS: slave address; latched when Go is accepted.
- WriteData, input, 8: data byte; latched when Go is accepted.
- ClockI2C, input, 1: half-bit timing signal from the baud-rate generator.
- BaudEnable, output, 1: drives the generator's Enable input.
- SCL, output, 1: I2C clock (push-pull).
- SDAOut, output, 1: SDA drive value; always 0 when SDAOutEnable=1.
- SDAOutEnable, output, 1: 1 = pull SDA low; 0 = release SDA (line high via pull-up).
- SDAIn, input, 1: sampled SDA level.
- Busy, output, 1: transaction in progress.
- Done, output, 1: one-clock completion pulse.
- AckError, output, 1: a NACK was seen in the last transaction; held until the next Go is accepted.

Behaviour:
- Reset values (Reset=0, effective immediately, including mid-transaction):
  - state IDLE; BaudEnable=0; SCL=1; SDAOutEnable=0; SDAOut=0; Busy=0; Done=0; AckError=0; ClkPrev=0; bit counter=0.
- Tick generation:
  - ClkPrev <= ClockI2C every clock.
  - tick = (ClockI2C != ClkPrev) && state != IDLE.
  - The controller never depends on the generator's output phase; both edges are ticks.
- IDLE:
  - Go=1 causes, on the next edge: latch shift register = {SlaveAddr, 1'b0}; latch WriteData; clear AckError; Busy=1; BaudEnable=1; SDAOutEnable=1 (START condition: SDA falls while SCL=1); go to START.
  - Go while Busy is ignored.
- START: on tick, SCL=0 and go to ADDR_LO with bit counter=ADDR_BITS.
- Each bit has two half-periods, each ending on a tick.
  - *_LO: SCL=0. At entry SDAOutEnable = ~current bit (MSB first). On tick, go to *_HI.
  - *_HI: SCL=1. On tick, SCL=0; then either decrement the counter and return to *_LO, or go to the ACK state when the counter reaches 0.
- ACK1_LO / ACK1_HI (address ACK):
  - SDA released throughout.
  - SDAIn is sampled on the tick that ends ACK1_HI; 1 = NACK, which sets AckError.
  - After ACK1_HI: go to DATA_LO (counter=7) if ACK, or if NACK with IGNORE_NACK=1; otherwise go to STOP_LO.
- DATA_LO / DATA_HI: 8 bits of WriteData, MSB first, same rules as the address phase.
- ACK2_LO / ACK2_HI: same as ACK1; NACK sets AckError; then always go to STOP_LO.
- STOP_LO: SCL=0, SDAOutEnable=1. On tick, go to STOP_HI.
- STOP_HI: SCL=1, SDA still low. On tick:
  - SDAOutEnable=0 (STOP condition), BaudEnable=0, Busy=0, Done=1 for one clock.
  - Go to IDLE.
- Total for a fully ACKed transaction with ADDR_BITS=7: 39 ticks from Go acceptance to Done.
- Simultaneous events:
  - Go in the same cycle that Done is asserted is ignored; Go is accepted only from the following cycle.
  - A tick in the IDLE cycle is discarded.
- SCL and SDA change only on tick cycles. SDA never changes while SCL=1, except for the START and STOP conditions.

Test Plan:
- Full write, bench ClockI2C toggling every 5 clocks, SlaveAddr=7'h48, WriteData=8'hA5, SDAIn=0 in both ACK slots:
  - SDA bit sequence 1001_0000 then 1010_0101.
  - Done exactly 39 ticks (195 clocks) after Go acceptance; AckError=0; BaudEnable high only while Busy.
- Address NACK, IGNORE_NACK=0, SDAIn=1 during ACK1_HI:
  - No data bits driven; STOP follows ACK1.
  - Done after 21 ticks; AckError=1.
- Address NACK, IGNORE_NACK=1: data byte still sent; Done after 39 ticks; AckError=1.
- Data NACK only: AckError=1 at Done; AckError cleared on the next accepted Go.
- Go pulsed during a transaction and in the Done cycle: both ignored; a Go one cycle later starts a new START.
- Reset driven 0 mid-DATA phase, asynchronously between clock edges: SCL=1, SDAOutEnable=0, BaudEnable=0, Busy=0 immediately; a new Go after release runs a normal transaction.
